mark_leaf_seq: RTL and testbench

- Clocked, parametrised last-mark evaluator for the Golomb ruler search engine.
- Advances the final mark position on request and checks each new difference against the distance set accumulated by earlier marks and against its own new differences.
- Reports success (a valid ruler), stay, or backtrack (hand control to LEVEL-1).
- Replaces the combinational leaf: the difference checks run as a multi-cycle FSM with a start/done handshake, optional auto-advance, and a success counter.

---
 rtl/mark_pkg.sv | 25 ++
 rtl/mark_leaf_seq_if.sv | 36 +++
 rtl/mark_dist_check.sv | 50 +++++
 rtl/mark_leaf_seq.sv | 178 +++++++++++++++++
 tb/tb_mark_leaf_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mark_pkg.sv
// Shared definitions for the Golomb ruler mark evaluators: default widths,
// FSM state encoding and the marks_in slice helper.
package mark_pkg;

  localparam int unsigned W_DEF        = 9;
  localparam int unsigned LW_DEF       = 7;
  localparam int unsigned MAXVALUE_DEF = 500;
  localparam int unsigned MARKS_MAX    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_CHECK,
    ST_REPORT
  } state_e;

  // m[0] sits in the most significant slice, m[npos] in the least significant.
  function automatic logic [31:0] mark_slice(input logic [MARKS_MAX-1:0] flat,
                                             input int unsigned         w,
                                             input int unsigned         npos,
                                             input int unsigned         i);
    return 32'(flat >> ((npos - i) * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/mark_leaf_seq_if.sv
// Request/response bundle between the search controller and a last-mark evaluator.
interface mark_leaf_seq_if #(
    parameter int W            = 9,
    parameter int LW           = 7,
    parameter int NUMPOSITIONS = 5,
    parameter int MAXVALUE     = 500,
    parameter int CW           = 16
) ();

    logic                           start;
    logic                           load;
    logic [W-1:0]                   resetvalue;
    logic [W-1:0]                   startvalue;
    logic [W-1:0]                   limit;
    logic [LW-1:0]                  enabled;
    logic [MAXVALUE:0]              distances;
    logic [(NUMPOSITIONS+1)*W-1:0]  marks_in;

    logic                           ready;
    logic                           done;
    logic [W-1:0]                   val;
    logic [LW-1:0]                  nextEnabled;
    logic                           success;
    logic [CW-1:0]                  found_count;

    modport master (
        output start, load, resetvalue, startvalue, limit, enabled, distances, marks_in,
        input  ready, done, val, nextEnabled, success, found_count
    );

    modport slave (
        input  start, load, resetvalue, startvalue, limit, enabled, distances, marks_in,
        output ready, done, val, nextEnabled, success, found_count
    );

endinterface

// File: rtl/mark_dist_check.sv
// Registered difference hash with a single-cycle conflict test of val-mark
// against the sampled distance set and the differences already accepted.
module mark_dist_check #(
    parameter int W        = 9,
    parameter int MAXVALUE = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              set_i,
    input  logic [W-1:0]      val_i,
    input  logic [W-1:0]      mark_i,
    input  logic [MAXVALUE:0] dist_i,
    output logic              conflict_o
);

    localparam int unsigned IW = $clog2(MAXVALUE + 1);

    logic [MAXVALUE:0] hash_q, hash_d;
    logic [W-1:0]      diff;
    logic              in_range;
    logic [IW-1:0]     idx;

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        diff       = val_i - mark_i;
        in_range   = 32'(diff) <= 32'(MAXVALUE);
        idx        = in_range ? IW'(diff) : '0;
        conflict_o = (mark_i >= val_i) || !in_range || dist_i[idx] || hash_q[idx];
    end

    always_comb begin
        hash_d = hash_q;
        if (clear_i) begin
            hash_d = '0;
        end else if (set_i) begin
            hash_d[idx] = 1'b1;
        end
    end

    // NOTE: the hash is a flop array, not RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hash_q <= '0;
        end else begin
            hash_q <= hash_d;
        end
    end

endmodule

// File: rtl/mark_leaf_seq.sv
// Sequential last-mark evaluator: steps the final mark, checks one earlier mark
// per cycle and reports success, stay or backtrack through a start/done handshake.
module mark_leaf_seq
    import mark_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int LW           = LW_DEF,
    parameter int LEVEL        = 5,
    parameter int NUMPOSITIONS = 5,
    parameter int MAXVALUE     = MAXVALUE_DEF,
    parameter int AUTO_ADVANCE = 0,
    parameter int CW           = 16
) (
    input logic             clock,
    input logic             reset,
    mark_leaf_seq_if.slave  bus
);

    localparam int unsigned MW = (NUMPOSITIONS + 1) * W;

    state_e            state_q, state_d;
    logic [W-1:0]      val_q, val_d;
    logic [W-1:0]      limit_q, limit_d;
    logic [LW-1:0]     next_en_q, next_en_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic              success_q, success_d;
    logic              pass_q, pass_d;
    logic [CW-1:0]     found_q, found_d;
    logic [MAXVALUE:0] dist_q, dist_d;
    logic [MW-1:0]     marks_q, marks_d;

    logic [W:0]        cand;
    logic [W-1:0]      mark_cur;
    logic              hash_clear;
    logic              hash_set;
    logic              conflict;

    assign mark_cur = W'(mark_slice(MARKS_MAX'(marks_q), W, NUMPOSITIONS, 32'(idx_q)));
    assign cand     = (val_q == '0) ? {1'b0, bus.startvalue} : {1'b0, val_q} + (W+1)'(1);

    mark_dist_check #(
        .W        (W),
        .MAXVALUE (MAXVALUE)
    ) u_dist_check (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (hash_clear),
        .set_i      (hash_set),
        .val_i      (val_q),
        .mark_i     (mark_cur),
        .dist_i     (dist_q),
        .conflict_o (conflict)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            val_q     <= '0;
            limit_q   <= '0;
            next_en_q <= LW'(LEVEL);
            idx_q     <= '0;
            success_q <= 1'b0;
            pass_q    <= 1'b0;
            found_q   <= '0;
            dist_q    <= '0;
            marks_q   <= '0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            limit_q   <= limit_d;
            next_en_q <= next_en_d;
            idx_q     <= idx_d;
            success_q <= success_d;
            pass_q    <= pass_d;
            found_q   <= found_d;
            dist_q    <= dist_d;
            marks_q   <= marks_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        limit_d    = limit_q;
        next_en_d  = next_en_q;
        idx_d      = idx_q;
        success_d  = success_q;
        pass_d     = pass_q;
        found_d    = found_q;
        dist_d     = dist_q;
        marks_d    = marks_q;
        hash_clear = 1'b0;
        hash_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    val_d     = bus.resetvalue;
                    next_en_d = bus.enabled;
                end else if (bus.start) begin
                    success_d = 1'b0;
                    state_d   = ST_STEP;
                    // A request for another level is passed through; STEP only delays it.
                    if (bus.enabled != LW'(LEVEL)) begin
                        pass_d    = 1'b1;
                        next_en_d = bus.enabled;
                    end else begin
                        pass_d  = 1'b0;
                        limit_d = bus.limit;
                        dist_d  = bus.distances;
                        marks_d = bus.marks_in;
                    end
                end
            end

            ST_STEP: begin
                if (pass_q) begin
                    state_d = ST_REPORT;
                end else if (cand[W] || (cand[W-1:0] > limit_q)) begin
                    val_d     = '0;
                    next_en_d = LW'(LEVEL - 1);
                    success_d = 1'b0;
                    state_d   = ST_REPORT;
                end else begin
                    val_d = cand[W-1:0];
                    if (LEVEL == 1) begin
                        success_d = 1'b1;
                        next_en_d = LW'(LEVEL);
                        state_d   = ST_REPORT;
                    end else begin
                        hash_clear = 1'b1;
                        idx_d      = LW'(1);
                        state_d    = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (!conflict) begin
                    hash_set = 1'b1;
                    if (idx_q == LW'(LEVEL - 1)) begin
                        success_d = 1'b1;
                        next_en_d = LW'(LEVEL);
                        state_d   = ST_REPORT;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end else if (AUTO_ADVANCE != 0) begin
                    state_d = ST_STEP;
                end else begin
                    success_d = 1'b0;
                    next_en_d = LW'(LEVEL);
                    state_d   = ST_REPORT;
                end
            end

            ST_REPORT: begin
                if (success_q && !(&found_q)) begin
                    found_d = found_q + CW'(1);
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ready       = (state_q == ST_IDLE);
        bus.done        = (state_q == ST_REPORT);
        bus.val         = val_q;
        bus.nextEnabled = next_en_q;
        bus.success     = success_q;
        bus.found_count = found_q;
    end

endmodule

// File: tb/tb_mark_leaf_seq.sv
// Directed bench for mark_leaf_seq at LEVEL=3: one instance returning on conflicts,
// one auto-advancing.
module tb_mark_leaf_seq;

    localparam int W   = 9;
    localparam int LW  = 7;
    localparam int LV  = 3;
    localparam int NP  = 5;
    localparam int MV  = 500;
    localparam int CW  = 16;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    int   lat;
    int   seen;

    mark_leaf_seq_if #(.W(W), .LW(LW), .NUMPOSITIONS(NP), .MAXVALUE(MV), .CW(CW)) bus_a ();
    mark_leaf_seq_if #(.W(W), .LW(LW), .NUMPOSITIONS(NP), .MAXVALUE(MV), .CW(CW)) bus_b ();

    mark_leaf_seq #(.W(W), .LW(LW), .LEVEL(LV), .NUMPOSITIONS(NP), .MAXVALUE(MV),
                    .AUTO_ADVANCE(0), .CW(CW)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    mark_leaf_seq #(.W(W), .LW(LW), .LEVEL(LV), .NUMPOSITIONS(NP), .MAXVALUE(MV),
                    .AUTO_ADVANCE(1), .CW(CW)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [MV:0] dist_set(input int a, input int b);
        logic [MV:0] d;
        d = '0;
        d[a] = 1'b1;
        if (b >= 0) d[b] = 1'b1;
        return d;
    endfunction

    function automatic logic [(NP+1)*W-1:0] mk(input int m1, input int m2);
        logic [(NP+1)*W-1:0] v;
        v = '0;
        v[(NP-1)*W +: W] = W'(m1);
        v[(NP-2)*W +: W] = W'(m2);
        return v;
    endfunction

    // Pulse start for one cycle, then count cycles until done (bounded).
    task automatic run_req(input bit sel, output int cycles);
        if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        cycles = 1;
        while (!(sel ? bus_b.done : bus_a.done) && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic load_val(input int v);
        bus_a.resetvalue = W'(v);
        bus_a.load = 1'b1;
        tick();
        bus_a.load = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus_a.start = 0; bus_a.load = 0; bus_a.resetvalue = '0; bus_a.startvalue = W'(3);
        bus_a.limit = W'(10); bus_a.enabled = LW'(3); bus_a.distances = dist_set(1, -1);
        bus_a.marks_in = mk(1, 0);
        bus_b.start = 0; bus_b.load = 0; bus_b.resetvalue = '0; bus_b.startvalue = W'(2);
        bus_b.limit = W'(10); bus_b.enabled = LW'(3); bus_b.distances = dist_set(1, -1);
        bus_b.marks_in = mk(1, 0);
        #12;
        check("rst_ready", 64'(bus_a.ready), 64'd1);
        check("rst_done", 64'(bus_a.done), 64'd0);
        check("rst_val", 64'(bus_a.val), 64'd0);
        check("rst_next", 64'(bus_a.nextEnabled), 64'd3);
        check("rst_success", 64'(bus_a.success), 64'd0);
        check("rst_found", 64'(bus_a.found_count), 64'd0);
        reset = 1'b1;
        tick();

        // val=0 -> startvalue 3: d=2, d=3 free
        run_req(0, lat);
        check("pass_lat", 64'(lat), 64'd4);
        check("pass_val", 64'(bus_a.val), 64'd3);
        check("pass_success", 64'(bus_a.success), 64'd1);
        check("pass_next", 64'(bus_a.nextEnabled), 64'd3);
        check("pass_ready_busy", 64'(bus_a.ready), 64'd0);
        tick();
        check("pass_found", 64'(bus_a.found_count), 64'd1);
        check("pass_ready_idle", 64'(bus_a.ready), 64'd1);
        check("pass_done_low", 64'(bus_a.done), 64'd0);

        // val=3 -> 4, marks {1,1}: d=3 accepted, then d=3 again hits the hash
        bus_a.marks_in = mk(1, 1);
        run_req(0, lat);
        check("hash_lat", 64'(lat), 64'd4);
        check("hash_val", 64'(bus_a.val), 64'd4);
        check("hash_success", 64'(bus_a.success), 64'd0);
        check("hash_next", 64'(bus_a.nextEnabled), 64'd3);
        tick();
        check("hash_found", 64'(bus_a.found_count), 64'd1);

        // val=4 -> 5: d=4 is in the distance set, conflict at k=1
        bus_a.marks_in = mk(1, 0);
        bus_a.distances = dist_set(1, 4);
        run_req(0, lat);
        check("dist_lat", 64'(lat), 64'd3);
        check("dist_val", 64'(bus_a.val), 64'd5);
        check("dist_success", 64'(bus_a.success), 64'd0);
        tick();

        // val=5 -> 6: m[1]=7 >= val, conflict at k=1
        bus_a.marks_in = mk(7, 0);
        bus_a.distances = dist_set(1, -1);
        run_req(0, lat);
        check("order_lat", 64'(lat), 64'd3);
        check("order_val", 64'(bus_a.val), 64'd6);
        check("order_success", 64'(bus_a.success), 64'd0);
        tick();

        // load 10 with limit 10: candidate 11 backtracks
        bus_a.marks_in = mk(1, 0);
        load_val(10);
        check("load_val", 64'(bus_a.val), 64'd10);
        check("load_next", 64'(bus_a.nextEnabled), 64'd3);
        run_req(0, lat);
        check("bt_lat", 64'(lat), 64'd2);
        check("bt_val", 64'(bus_a.val), 64'd0);
        check("bt_next", 64'(bus_a.nextEnabled), 64'd2);
        check("bt_success", 64'(bus_a.success), 64'd0);
        tick();

        // enabled=2 passes through with val untouched
        load_val(5);
        bus_a.enabled = LW'(2);
        run_req(0, lat);
        check("thru_lat", 64'(lat), 64'd2);
        check("thru_val", 64'(bus_a.val), 64'd5);
        check("thru_next", 64'(bus_a.nextEnabled), 64'd2);
        check("thru_success", 64'(bus_a.success), 64'd0);
        tick();
        check("thru_found", 64'(bus_a.found_count), 64'd1);

        // candidate equal to a shrunk limit is still accepted
        bus_a.enabled = LW'(3);
        load_val(4);
        bus_a.limit = W'(5);
        run_req(0, lat);
        check("edge_lat", 64'(lat), 64'd4);
        check("edge_val", 64'(bus_a.val), 64'd5);
        check("edge_success", 64'(bus_a.success), 64'd1);
        tick();
        check("edge_found", 64'(bus_a.found_count), 64'd2);

        // start together with load: load wins, no request launched
        bus_a.resetvalue = W'(7);
        bus_a.load = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.load = 1'b0;
        bus_a.start = 1'b0;
        check("both_val", 64'(bus_a.val), 64'd7);
        check("both_ready", 64'(bus_a.ready), 64'd1);
        tick();
        check("both_done", 64'(bus_a.done), 64'd0);
        check("both_ready2", 64'(bus_a.ready), 64'd1);

        // reset in the middle of CHECK abandons the request
        bus_a.limit = W'(20);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("mid_val", 64'(bus_a.val), 64'd0);
        check("mid_ready", 64'(bus_a.ready), 64'd1);
        check("mid_done", 64'(bus_a.done), 64'd0);
        check("mid_found", 64'(bus_a.found_count), 64'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen += int'(bus_a.done);
        end
        check("mid_no_done", 64'(seen), 64'd0);

        // load 7, then start checks 8: d=7, d=8 free
        load_val(7);
        run_req(0, lat);
        check("after_lat", 64'(lat), 64'd4);
        check("after_val", 64'(bus_a.val), 64'd8);
        check("after_success", 64'(bus_a.success), 64'd1);
        tick();
        check("after_found", 64'(bus_a.found_count), 64'd1);

        // auto-advance: 2 rejected (d=1), 3 accepted, single done
        run_req(1, lat);
        check("aa_lat", 64'(lat), 64'd6);
        check("aa_val", 64'(bus_b.val), 64'd3);
        check("aa_success", 64'(bus_b.success), 64'd1);
        check("aa_next", 64'(bus_b.nextEnabled), 64'd3);
        tick();
        check("aa_done_once", 64'(bus_b.done), 64'd0);
        check("aa_found", 64'(bus_b.found_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
